// File: rtl/object_table_writer.sv
// Object table: fills the lowest free slot with converted objects, takes physics
// writebacks, serves one-cycle reads, and walks a slot-by-slot clear.
module object_table_writer #(
    parameter int NUM_OBJECTS = 8,
    parameter int IDX_W       = $clog2(NUM_OBJECTS)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    input  logic                   is_static,
    input  logic [1:0]             id_bits,
    input  logic [35:0]            params,
    input  logic [9:0]             pos_x,
    input  logic [9:0]             pos_y,
    input  logic [15:0]            vel_x,
    input  logic [15:0]            vel_y,
    output logic [IDX_W-1:0]       ins_idx_out,
    output logic                   ins_done_out,
    input  logic                   upd_valid_in,
    input  logic [IDX_W-1:0]       upd_idx_in,
    input  logic [9:0]             upd_pos_x_in,
    input  logic [9:0]             upd_pos_y_in,
    input  logic [15:0]            upd_vel_x_in,
    input  logic [15:0]            upd_vel_y_in,
    input  logic                   rd_req_in,
    input  logic [IDX_W-1:0]       rd_idx_in,
    output logic                   rd_valid_out,
    output logic [90:0]            rd_data_out,
    input  logic                   clear_in,
    output logic [NUM_OBJECTS-1:0] occupied_out,
    output logic [IDX_W:0]         count_out,
    output logic                   full_out,
    output logic                   busy_out
);

    localparam int REC_W = 91;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_OBJECTS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       clr_idx;
    logic [REC_W-1:0]       recs [NUM_OBJECTS];
    logic [NUM_OBJECTS-1:0] occ;
    logic [IDX_W-1:0]       free_idx;
    logic [IDX_W:0]         cnt;
    logic                   commit;
    logic                   upd_ok;
    logic                   rd_ok;
    logic [REC_W-1:0]       new_rec;

    always_comb begin
        free_idx = '0;
        for (int i = NUM_OBJECTS - 1; i >= 0; i--) begin
            if (!occ[i]) free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < NUM_OBJECTS; i++) begin
            cnt = cnt + (IDX_W + 1)'(occ[i]);
        end
    end

    assign count_out    = cnt;
    assign occupied_out = occ;
    assign full_out     = (cnt == (IDX_W + 1)'(NUM_OBJECTS));
    assign busy_out     = (state_q == CLEAR);
    // Gated by reset so the handshake is closed while reset is held.
    assign ready_out    = rst_in && (state_q == IDLE) && !full_out && !clear_in;

    assign new_rec = {is_static, id_bits, params, pos_y, pos_x, vel_x, vel_y};
    assign commit  = valid_in && ready_out && (id_bits != 2'b00);
    assign upd_ok  = upd_valid_in && !busy_out && occ[upd_idx_in]
                   && !recs[upd_idx_in][90];
    assign rd_ok   = rd_req_in && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clear_in) state_d = CLEAR;
            CLEAR:   if (clr_idx == LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            clr_idx      <= '0;
            occ          <= '0;
            ins_done_out <= 1'b0;
            ins_idx_out  <= '0;
            rd_valid_out <= 1'b0;
            rd_data_out  <= '0;
            for (int i = 0; i < NUM_OBJECTS; i++) recs[i] <= '0;
        end else begin
            state_q      <= state_d;
            ins_done_out <= commit;
            rd_valid_out <= rd_ok;
            rd_data_out  <= (rd_ok && occ[rd_idx_in]) ? recs[rd_idx_in] : '0;
            if (state_q == CLEAR) begin
                clr_idx       <= clr_idx + IDX_W'(1);
                recs[clr_idx] <= '0;
                occ[clr_idx]  <= 1'b0;
            end else begin
                clr_idx <= '0;
            end
            if (commit) begin
                recs[free_idx] <= new_rec;
                occ[free_idx]  <= 1'b1;
                ins_idx_out    <= free_idx;
            end
            // Header fields (static, id, params) stay untouched by writeback.
            if (upd_ok) begin
                recs[upd_idx_in][51:0] <= {upd_pos_y_in, upd_pos_x_in,
                                           upd_vel_x_in, upd_vel_y_in};
            end
        end
    end

endmodule
